// File: rtl/scratch_pad_banked_if.sv
`default_nettype none
// ============================================================================
// Module   : scratch_pad_banked_if
// Purpose  : Request, response and clear-control bundle for scratch_pad_banked.
// Revision : 1.0
// ============================================================================
interface scratch_pad_banked_if #(
    parameter int DWidth = 32,
    parameter int Depth  = 4096
);
    localparam int Index = $clog2(Depth);

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [DWidth/8-1:0]   req_be_i;
    logic [Index-1:0]      req_addr_i;
    logic [DWidth-1:0]     req_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DWidth-1:0]     rsp_rdata_o;
    logic                  clear_i;
    logic                  busy_o;
    logic                  clear_done_o;

    modport master (
        output req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i,
        output rsp_ready_i, clear_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o, clear_done_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i, clear_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o, clear_done_o
    );
endinterface
`default_nettype wire

// File: rtl/scratch_pad_banked.sv
`default_nettype none
// ============================================================================
// Module   : scratch_pad_banked
// Purpose  : Banked SRAM1RW1024x8 scratch pad with valid/ready requests,
//            in-order read-response FIFO and a hardware zero-fill engine.
// Revision : 1.0
// ============================================================================
module scratch_pad_banked #(
    parameter int DWidth   = 32,
    parameter int Depth    = 4096,
    parameter int RspDepth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    scratch_pad_banked_if.slave bus
);
    localparam int Lanes = DWidth / 8;
    localparam int Banks = Depth / 1024;
    localparam int Index = $clog2(Depth);
    localparam int BankW = (Banks > 1) ? $clog2(Banks) : 1;
    localparam int PtrW  = $clog2(RspDepth);
    localparam int CntW  = $clog2(RspDepth + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                          state_q, state_d;
    logic                            pend_q, pend_d;
    logic [9:0]                      cnt_q, cnt_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            run_q;
    logic [1:0]                      inflight_q, inflight_d;
    logic                            rd_pend_q, rd_pend_d;
    logic [BankW-1:0]                rd_bank_q, rd_bank_d;
    logic                            stage_v_q, stage_v_d;
    logic [DWidth-1:0]               stage_data_q, stage_data_d;
    logic [RspDepth-1:0][DWidth-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]                 count_q, count_d;
    logic [DWidth-1:0]               last_q, last_d;

    logic                            accept, rd_acc, push, pop, clearing;
    logic [BankW-1:0]                bank_sel;
    logic [9:0]                      maddr;
    logic [DWidth-1:0]               mdin;
    logic [Banks-1:0][DWidth-1:0]    bank_rdata;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // run_q keeps ready low while reset is asserted and for the first edge after it
    assign bus.req_ready_o = run_q && (state_q == ST_IDLE) && !pend_q && !bus.clear_i &&
                             ((int'(count_q) + int'(inflight_q)) < RspDepth);
    assign accept   = bus.req_valid_i && bus.req_ready_o;
    assign rd_acc   = accept && !bus.req_we_i;
    assign clearing = (state_q == ST_CLEAR);
    assign push     = stage_v_q;
    assign pop      = (count_q != '0) && bus.rsp_ready_i;

    assign bus.rsp_valid_o  = (count_q != '0);
    assign bus.rsp_rdata_o  = (count_q != '0) ? fifo_q[rd_ptr_q] : last_q;
    assign bus.busy_o       = busy_q;
    assign bus.clear_done_o = done_q;

    if (Banks > 1) begin : g_multi_bank
        assign bank_sel = bus.req_addr_i[Index-1:10];
    end else begin : g_single_bank
        assign bank_sel = '0;
    end

    assign maddr = clearing ? cnt_q : bus.req_addr_i[9:0];
    assign mdin  = clearing ? '0 : bus.req_wdata_i;

    // Behavioural equivalent of one SRAM1RW1024x8 per lane: synchronous read into dout_q
    for (genvar b = 0; b < Banks; b++) begin : g_bank
        logic sel, csb, oeb;
        assign sel = accept && (bank_sel == BankW'(b));
        assign csb = !(clearing || sel);
        assign oeb = !(sel && !bus.req_we_i);
        for (genvar k = 0; k < Lanes; k++) begin : g_lane
            logic       web;
            logic [7:0] mem_q [1024];
            logic [7:0] dout_q;
            assign web = clearing ? 1'b0 : !(sel && bus.req_we_i && bus.req_be_i[k]);
            always_ff @(posedge clk_i) begin
                if (!csb) begin
                    if (!web)      mem_q[maddr] <= mdin[8*k +: 8];
                    else if (!oeb) dout_q       <= mem_q[maddr];
                end
            end
            assign bank_rdata[b][8*k +: 8] = dout_q;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.clear_i) begin
                    if (inflight_q == 2'd0) begin
                        state_d = ST_CLEAR;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        pend_d  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (inflight_q == 2'd0) begin
                    state_d = ST_CLEAR;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_q == 10'd1023) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_comb begin
        rd_pend_d    = rd_acc;
        rd_bank_d    = rd_acc ? bank_sel : rd_bank_q;
        stage_v_d    = rd_pend_q;
        stage_data_d = rd_pend_q ? bank_rdata[rd_bank_q] : stage_data_q;

        inflight_d = inflight_q;
        if (rd_acc && !push)      inflight_d = inflight_q + 2'd1;
        else if (!rd_acc && push) inflight_d = inflight_q - 2'd1;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = stage_data_q;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        last_d = bus.rsp_rdata_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            pend_q       <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            run_q        <= 1'b0;
            inflight_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_bank_q    <= '0;
            stage_v_q    <= 1'b0;
            stage_data_q <= '0;
            fifo_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_q       <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            run_q        <= 1'b1;
            inflight_q   <= inflight_d;
            rd_pend_q    <= rd_pend_d;
            rd_bank_q    <= rd_bank_d;
            stage_v_q    <= stage_v_d;
            stage_data_q <= stage_data_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_q       <= last_d;
        end
    end
endmodule
`default_nettype wire

// File: doc/scratch_pad_banked.md
Name: scratch_pad_banked

Overview:
- Parametrised multi-macro scratch pad built from SRAM1RW1024x8 macros. Provides a DWidth-bit × Depth-word memory with a valid/ready request port, byte-enable writes, and a backpressured read-response queue.
- Includes a hardware clear engine that zero-fills the whole array.
- Successor to the single-macro 1024×8 scratch pad. Feeds MLP weight and activation buffers.

Parameters:
- DWidth, 32, word width in bits; must be a multiple of 8 (Lanes = DWidth/8 macros per bank).
- Depth, 4096, words; must be a multiple of 1024 (Banks = Depth/1024).
- RspDepth, 4, response FIFO entries; must be ≥2.
- Index (localparam), $clog2(Depth), address width.

Ports:
- clk_i  input  1  clock; also drives macro CE.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted when valid&&ready at a rising edge.
- req_we_i  input  1  1=write, 0=read.
- req_be_i  input  DWidth/8  byte enables, writes only.
- req_addr_i  input  Index  word address.
- req_wdata_i  input  DWidth  write data.
- rsp_valid_o  output  1  read data valid (FIFO head).
- rsp_ready_i  input  1  consumer pops the head on valid&&ready.
- rsp_rdata_o  output  DWidth  read data.
- clear_i  input  1  single-cycle zero-fill request.
- busy_o  output  1  high while clear is pending or running.
- clear_done_o  output  1  one-cycle pulse after the last clear write.

Behaviour:
- Reset (async, rst_ni=0):
  - FSM goes to IDLE; FIFO, in-flight counter and clear-pending are cleared.
  - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, busy_o=0, clear_done_o=0.
  - Macro contents are not cleared.
  - Reset mid-clear or with reads in flight discards all pending reads and any clear progress.
- Address decode:
  - bank = addr[Index-1:10]; macro address = addr[9:0].
  - Lane k maps to bits [8k+7:8k]. Only the selected bank asserts CSB=0; all other banks hold CSB=1.
- Write, accepted at edge N:
  - Selected bank gets CSB=0 and per-lane WEB=~be[k], so be=0 lanes are untouched.
  - No response is generated. A write with be=0 is a legal no-op.
- Read, accepted at edge N:
  - Selected bank gets CSB=0, WEB=1, OEB=0.
  - Macro data is captured at edge N+1 into the stage register, then pushed to the FIFO at edge N+2.
  - rsp_valid_o rises in cycle N+2 when the FIFO was empty. Minimum latency is 2 cycles.
  - Responses are returned strictly in request order. Banks are selected one-hot, so only the selected bank's output is muxed in.
- Flow control:
  - req_ready_o = (state==IDLE) && !clear_pending && (fifo_count + inflight < RspDepth).
  - inflight counts accepted reads not yet pushed (0..2).
  - A FIFO pop and push in the same cycle leave the count unchanged.
  - A full FIFO must never overflow. Throughput is 1 req/cycle while rsp_ready_i=1.
- Clear FSM:
  - States: IDLE, WAIT, CLEAR, DONE.
  - IDLE + clear_i: go to CLEAR if inflight==0, otherwise go to WAIT and set clear_pending; busy_o=1 from the next cycle.
  - WAIT → CLEAR when inflight==0.
  - CLEAR: a 10-bit counter writes 0 to address cnt in all banks and all lanes in parallel (all CSB=0, all WEB=0), for 1024 cycles.
  - CLEAR → DONE at cnt==1023. DONE pulses clear_done_o for one cycle, then returns to IDLE.
  - busy_o stays high through DONE. req_ready_o=0 in all non-IDLE states.
  - clear_i while busy is ignored. clear_i and req_valid_i in the same IDLE cycle: the clear wins and the request is not accepted.
  - The FIFO may drain during a clear; responses already queued keep their pre-clear data.
- Macro control when idle: all CSB=1, WEB=1, OEB=1.
- rsp_rdata_o holds its value when rsp_valid_o=0. Out-of-range addresses cannot occur by construction.

Test Plan:
- Reset, then write 0xDEADBEEF @0x000 be=4'hF and 0x12345678 @0xC05 be=4'hF; read both → responses 0xDEADBEEF then 0x12345678, each 2 cycles after acceptance.
- Write 0xAABBCCDD @0x400 be=4'hF, then 0x11223344 @0x400 be=4'b0101; read @0x400 → 0xAA22CC44.
- Hold rsp_ready_i=0 and issue 6 back-to-back reads → exactly 4 accepted and req_ready_o=0 afterwards; release → 4 in-order responses, then the remaining 2 are accepted.
- Fill 0x07F with 0xFFFFFFFF, pulse clear_i with 2 reads in flight → FSM enters WAIT, both responses still return 0xFFFFFFFF; clear_done_o pulses 1024 cycles after CLEAR entry; then read 0x07F and 0xFFF → 0x00000000.
- Assert clear_i and req_valid_i in the same cycle → request not accepted, busy_o=1 next cycle; clear_i mid-CLEAR is ignored, with a single clear_done_o pulse.
- Drop rst_ni at counter=500 during CLEAR → busy_o=0 and rsp_valid_o=0 immediately; after release req_ready_o=1 and the FSM is in IDLE.
